// File: rtl/convolution_if.sv
// Pixel-stream, coefficient and filtered-output signals between the line buffer side and the convolution block.
interface convolution_if #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned HCOUNT_WIDTH = 11,
    parameter int unsigned VCOUNT_WIDTH = 10
);
    logic [2:0][DATA_WIDTH-1:0]   data_in;
    logic                         data_valid_in;
    logic [HCOUNT_WIDTH-1:0]      hcount_in;
    logic [VCOUNT_WIDTH-1:0]      vcount_in;
    logic signed [2:0][2:0][7:0]  coeffs_in;
    logic signed [7:0]            shift_in;
    logic [DATA_WIDTH-1:0]        line_out;
    logic                         data_valid_out;
    logic [HCOUNT_WIDTH-1:0]      hcount_out;
    logic [VCOUNT_WIDTH-1:0]      vcount_out;

    modport master (
        output data_in, data_valid_in, hcount_in, vcount_in, coeffs_in, shift_in,
        input  line_out, data_valid_out, hcount_out, vcount_out
    );

    modport slave (
        input  data_in, data_valid_in, hcount_in, vcount_in, coeffs_in, shift_in,
        output line_out, data_valid_out, hcount_out, vcount_out
    );
endinterface

// File: rtl/convolution.sv
// 3x3 sliding-window convolution: window -> products -> sum -> shift/clamp, one window per cycle.
// Define CONV_ABS_EN to take the magnitude of the sum before the shift.
module convolution #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned HCOUNT_WIDTH = 11,
    parameter int unsigned VCOUNT_WIDTH = 10
) (
    input logic          clk_in,
    input logic          rst_in,
    convolution_if.slave bus
);
    localparam int unsigned PROD_WIDTH = DATA_WIDTH + 9;
    localparam int unsigned SUM_WIDTH  = DATA_WIDTH + 13;

    logic [2:0][2:0][DATA_WIDTH-1:0] r_win;   // [col][row], col 0 oldest
    logic [1:0]                      r_fill;
    logic [1:0]                      w_fill_next;
    logic                            w_issue;
    logic                            r_w_valid;
    logic [HCOUNT_WIDTH-1:0]         r_w_hcount;
    logic [VCOUNT_WIDTH-1:0]         r_w_vcount;

    logic signed [PROD_WIDTH-1:0]    w_prod [3][3];
    logic signed [PROD_WIDTH-1:0]    r_prod [3][3];
    logic                            r_p_valid;
    logic [HCOUNT_WIDTH-1:0]         r_p_hcount;
    logic [VCOUNT_WIDTH-1:0]         r_p_vcount;

    logic signed [SUM_WIDTH-1:0]     w_sum;
    logic signed [SUM_WIDTH-1:0]     r_s_sum;
    logic                            r_s_valid;
    logic [HCOUNT_WIDTH-1:0]         r_s_hcount;
    logic [VCOUNT_WIDTH-1:0]         r_s_vcount;

    logic signed [SUM_WIDTH-1:0]     w_mag;
    logic signed [SUM_WIDTH-1:0]     w_shifted;
    logic [3:0]                      w_shamt;
    logic [DATA_WIDTH-1:0]           w_pix;
    logic [DATA_WIDTH-1:0]           r_line;
    logic                            r_valid;
    logic [HCOUNT_WIDTH-1:0]         r_hcount;
    logic [VCOUNT_WIDTH-1:0]         r_vcount;
    logic                            w_unused;

    assign w_unused = ^bus.shift_in[6:4];

    // Fill count restarts at each line start; a window is issued once three columns of the line are held.
    always_comb begin
        w_fill_next = r_fill;
        if (bus.data_valid_in) begin
            if (bus.hcount_in == '0) begin
                w_fill_next = 2'd1;
            end else if (r_fill != 2'd3) begin
                w_fill_next = r_fill + 2'd1;
            end
        end
        w_issue = bus.data_valid_in && (w_fill_next == 2'd3);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_win      <= '0;
            r_fill     <= '0;
            r_w_valid  <= 1'b0;
            r_w_hcount <= '0;
            r_w_vcount <= '0;
        end else begin
            r_fill    <= w_fill_next;
            r_w_valid <= w_issue;
            if (bus.data_valid_in) begin
                r_win      <= {bus.data_in, r_win[2], r_win[1]};
                r_w_hcount <= bus.hcount_in - HCOUNT_WIDTH'(1);
                r_w_vcount <= bus.vcount_in;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_prod[r][c] = PROD_WIDTH'($signed({1'b0, r_win[c][r]}))
                             * PROD_WIDTH'($signed(bus.coeffs_in[r][c]));
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_prod[r][c] <= '0;
                end
            end
            r_p_valid  <= 1'b0;
            r_p_hcount <= '0;
            r_p_vcount <= '0;
        end else begin
            r_prod     <= w_prod;
            r_p_valid  <= r_w_valid;
            r_p_hcount <= r_w_hcount;
            r_p_vcount <= r_w_vcount;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_sum = w_sum + SUM_WIDTH'(r_prod[r][c]);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s_sum    <= '0;
            r_s_valid  <= 1'b0;
            r_s_hcount <= '0;
            r_s_vcount <= '0;
        end else begin
            r_s_sum    <= w_sum;
            r_s_valid  <= r_p_valid;
            r_s_hcount <= r_p_hcount;
            r_s_vcount <= r_p_vcount;
        end
    end

    // Negative shift amounts mean no shift; the result saturates into the unsigned pixel range.
    always_comb begin
`ifdef CONV_ABS_EN
        w_mag = r_s_sum[SUM_WIDTH-1] ? -r_s_sum : r_s_sum;
`else
        w_mag = r_s_sum;
`endif
        w_shamt   = bus.shift_in[7] ? 4'd0 : bus.shift_in[3:0];
        w_shifted = w_mag >>> w_shamt;
        if (w_shifted[SUM_WIDTH-1]) begin
            w_pix = '0;
        end else if (|w_shifted[SUM_WIDTH-2:DATA_WIDTH]) begin
            w_pix = '1;
        end else begin
            w_pix = w_shifted[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_line   <= '0;
            r_valid  <= 1'b0;
            r_hcount <= '0;
            r_vcount <= '0;
        end else begin
            r_line   <= w_pix;
            r_valid  <= r_s_valid;
            r_hcount <= r_s_hcount;
            r_vcount <= r_s_vcount;
        end
    end

    assign bus.line_out       = r_line;
    assign bus.data_valid_out = r_valid;
    assign bus.hcount_out     = r_hcount;
    assign bus.vcount_out     = r_vcount;
endmodule

// File: tb/tb_convolution.sv
// Scoreboard bench for convolution: window model pushes expected pixels, a negedge monitor pops and compares.
module tb_convolution;
    localparam int unsigned DW = 8;
    localparam int unsigned HW = 11;
    localparam int unsigned VW = 10;

    typedef struct {
        int pix;
        int h;
        int v;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    int cols[3][3];   // [col][row], col 0 oldest
    int coef[3][3];   // [row][col]
    int shift_m;
    int fill_m;

    convolution_if #(.DATA_WIDTH(DW), .HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW)) bus ();

    convolution #(.DATA_WIDTH(DW), .HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Filter rule: signed MAC, floor shift by shift[3:0] (negative -> 0), clamp to pixel range.
    function automatic int ref_pix();
        int sum = 0;
        int s;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                sum += cols[c][r] * coef[r][c];
`ifdef CONV_ABS_EN
        if (sum < 0) sum = -sum;
`endif
        s = (shift_m < 0) ? 0 : (shift_m & 15);
        sum = sum >>> s;
        if (sum < 0) return 0;
        if (sum > 255) return 255;
        return sum;
    endfunction

    task automatic model_reset();
        fill_m = 0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                cols[c][r] = 0;
        exp_q.delete();
    endtask

    task automatic set_k(input int k[9], input int sh);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                coef[r][c] = k[r*3+c];
                bus.coeffs_in[r][c] = 8'(k[r*3+c]);
            end
        shift_m = sh;
        bus.shift_in = 8'(sh);
    endtask

    // One valid column; ovr >= 0 supplies a hand-derived expected pixel for an issuing beat.
    task automatic beat(input int h, input int v, input int p0, input int p1, input int p2, input int ovr);
        exp_t e;
        @(negedge clk);
        bus.data_valid_in = 1'b1;
        bus.hcount_in     = HW'(h);
        bus.vcount_in     = VW'(v);
        bus.data_in[0]    = DW'(p0);
        bus.data_in[1]    = DW'(p1);
        bus.data_in[2]    = DW'(p2);
        cols[0] = cols[1];
        cols[1] = cols[2];
        cols[2] = '{p0, p1, p2};
        fill_m = (h == 0) ? 1 : ((fill_m < 3) ? fill_m + 1 : 3);
        if (fill_m == 3) begin
            e.pix = (ovr >= 0) ? ovr : ref_pix();
            e.h   = (h - 1) & ((1 << HW) - 1);
            e.v   = v;
            e.cyc = cyc + 4;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.data_valid_in = 1'b0;
        bus.hcount_in     = HW'($urandom);
        bus.data_in       = 24'($urandom);
    endtask

    task automatic drain();
        exp_t e;
        repeat (8) idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_output: got no output, required line=%0d h=%0d by cycle %0d", e.pix, e.h, e.cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.data_valid_out) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got line=%0d h=%0d at cycle %0d, required no output",
                         bus.line_out, bus.hcount_out, cyc);
            end else begin
                e = exp_q.pop_front();
                if (int'(bus.line_out) != e.pix || int'(bus.hcount_out) != e.h ||
                    int'(bus.vcount_out) != e.v || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL output: got line=%0d h=%0d v=%0d cyc=%0d, required line=%0d h=%0d v=%0d cyc=%0d",
                             bus.line_out, bus.hcount_out, bus.vcount_out, cyc, e.pix, e.h, e.v, e.cyc);
                end
            end
        end
    end

    initial begin
        int k[9];
        int h;
        int got;
        bus.data_valid_in = 1'b0;
        bus.data_in       = '0;
        bus.hcount_in     = '0;
        bus.vcount_in     = '0;
        bus.coeffs_in     = '0;
        bus.shift_in      = '0;
        model_reset();
        #12;
        check("reset_line", int'(bus.line_out), 0);
        check("reset_valid", int'(bus.data_valid_out), 0);
        check("reset_hcount", int'(bus.hcount_out), 0);
        check("reset_vcount", int'(bus.vcount_out), 0);
        @(negedge clk);
        rst = 1'b0;

        // Identity
        k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        set_k(k, 0);
        beat(0, 5, 50, 50, 50, -1);
        beat(1, 5, 50, 200, 50, -1);
        beat(2, 5, 50, 50, 50, 200);
        drain();

        // Gaussian
        k = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        set_k(k, 4);
        beat(0, 9, 100, 100, 100, -1);
        beat(1, 9, 100, 100, 100, -1);
        beat(2, 9, 100, 100, 100, 100);
        beat(0, 10, 0, 0, 0, -1);
        beat(1, 10, 0, 255, 0, -1);
        beat(2, 10, 0, 0, 0, 63);
        drain();

        // Sobel X
        k = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
        set_k(k, 0);
        beat(0, 3, 255, 255, 255, -1);
        beat(1, 3, 0, 0, 0, -1);
        beat(2, 3, 0, 0, 0, 255);
        beat(0, 4, 0, 0, 0, -1);
        beat(1, 4, 0, 0, 0, -1);
`ifdef CONV_ABS_EN
        beat(2, 4, 255, 255, 255, 255);
`else
        beat(2, 4, 255, 255, 255, 0);
`endif
        drain();

        // Zero coefficients
        k = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        set_k(k, 0);
        for (int i = 0; i < 5; i++)
            beat(i, 7, int'($urandom_range(0, 255)), 255, int'($urandom_range(0, 255)), 0);
        drain();

        // Line start, including a restart mid-line
        k = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        set_k(k, 4);
        for (int i = 0; i < 4; i++)
            beat(i, 20, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);
        for (int i = 0; i < 3; i++)
            beat(i, 21, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);
        drain();

        // Gapped input
        for (int i = 0; i < 8; i++) begin
            beat(i, 30, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);
            idle();
        end
        drain();

        // Reset with three windows in flight
        for (int i = 0; i < 5; i++)
            beat(i, 40, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);
        idle();
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(negedge clk);
            if (bus.data_valid_out) got = 1;
        end
        check("reset_inflight_seen", got, 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("reset_async_valid", int'(bus.data_valid_out), 0);
        check("reset_async_line", int'(bus.line_out), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 5; i < 8; i++)
            beat(i, 41, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);
        drain();

        // Randomized blocks
        for (int blk = 0; blk < 20; blk++) begin
            for (int j = 0; j < 9; j++) k[j] = int'($urandom_range(0, 255)) - 128;
            set_k(k, int'($urandom_range(0, 39)) - 8);
            h = 0;
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 2) == 0) idle();
                beat(h, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);
                h = ($urandom_range(0, 9) == 0) ? 0 : h + 1;
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
